// File: rtl/mystic_pkg.sv
// mystic_pkg
//   Shared definitions for the instruction-fetch responder: FSM state
//   encoding, the RVC "full-length instruction" quadrant code, reset
//   constants and a word-address increment helper.
package mystic_pkg;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_REQ_LO = 2'd1,
        S_REQ_HI = 2'd2,
        S_RESP   = 2'd3
    } fetch_state_e;

    // Low two bits of a halfword equal to this mark a 32-bit instruction.
    localparam logic [1:0]  RVC_QUADRANT_FULL = 2'b11;

    localparam logic [31:0] RST_WORD = 32'h0000_0000;
    localparam logic [15:0] RST_HALF = 16'h0000;
    localparam logic [29:0] RST_TAG  = 30'h0;

    // Address of the next aligned word; wraps modulo 2^32.
    function automatic logic [31:0] next_word_addr(input logic [29:0] word_idx);
        return {word_idx + 30'd1, 2'b00};
    endfunction

endpackage

// File: rtl/mystic_fetch_align.sv
// mystic_fetch_align
//   Combinational halfword select for a fetched 32-bit word.
//   Ports:
//     word_i     in  32  aligned memory word (or buffered word)
//     pc1_i      in  1   PC[1]: selects upper (1) or lower (0) halfword
//     half_o     out 16  selected halfword
//     is_c_o     out 1   selected halfword starts a compressed instruction
//     need_hi_o  out 1   32-bit instruction straddles into the next word
module mystic_fetch_align
    import mystic_pkg::*;
(
    input  logic [31:0] word_i,
    input  logic        pc1_i,
    output logic [15:0] half_o,
    output logic        is_c_o,
    output logic        need_hi_o
);

    always_comb begin
        half_o    = pc1_i ? word_i[31:16] : word_i[15:0];
        is_c_o    = (half_o[1:0] != RVC_QUADRANT_FULL);
        // Only an upper-half start can run off the end of the word.
        need_hi_o = pc1_i && !is_c_o;
    end

endmodule

// File: rtl/mystic_instr_fetch.sv
// mystic_instr_fetch
//   Instruction-fetch responder between the PC controller and IMEM. On a
//   PC_read_i strobe it returns the instruction at PC_i (RVC aware, halfword
//   aligned), reading one or two words from memory, and pulses
//   instr_ready_o for one cycle. A one-word buffer serves refetches from the
//   most recently fetched word without a memory access.
//   Ports:
//     clk_i, rst_i                     clock, async active-high reset
//     PC_read_i, PC_i                  fetch strobe and address
//     buf_inv_i                        drop the buffered word
//     instr_o, is_compressed_o         response instruction
//     instr_ready_o, instr_err_o       response strobe, misaligned error
//     mem_req_o, mem_addr_o            memory read request (held until valid)
//     mem_valid_i, mem_rdata_i         memory read response
module mystic_instr_fetch
    import mystic_pkg::*;
#(
    parameter int unsigned ENABLE_C = 1,
    parameter int unsigned BUF_EN   = 1
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        PC_read_i,
    input  logic [31:0] PC_i,
    input  logic        buf_inv_i,
    output logic [31:0] instr_o,
    output logic        is_compressed_o,
    output logic        instr_ready_o,
    output logic        instr_err_o,
    output logic        mem_req_o,
    output logic [31:0] mem_addr_o,
    input  logic        mem_valid_i,
    input  logic [31:0] mem_rdata_i
);

    fetch_state_e state_q, state_d;
    logic [31:1]  pc_q, pc_d;
    logic [31:0]  addr_q, addr_d;
    logic [15:0]  half_q, half_d;
    logic [31:0]  pend_instr_q, pend_instr_d;
    logic         pend_c_q, pend_c_d;
    logic         pend_err_q, pend_err_d;
    logic [31:0]  instr_q, instr_d;
    logic         is_c_q, is_c_d;
    logic         err_q, err_d;
    logic         ready_q, ready_d;
    logic         buf_valid_q, buf_valid_d;
    logic [29:0]  buf_tag_q, buf_tag_d;
    logic [31:0]  buf_data_q, buf_data_d;
    // Set when the buffer is invalidated while a memory read is in flight;
    // the word that read returns may be stale and must not be cached.
    logic         nocache_q, nocache_d;

    logic         in_idle, in_req;
    logic         misaligned;
    logic         buf_hit;
    logic         lo_avail;
    logic         cache_ok;
    logic [31:0]  lo_word;
    logic         lo_pc1;
    logic [29:0]  lo_idx;
    logic [15:0]  al_half;
    logic         al_is_c;
    logic         al_need_hi;
    logic         unused_pc0;

    assign unused_pc0 = PC_i[0];

    assign in_idle    = (state_q == S_IDLE);
    assign in_req     = (state_q == S_REQ_LO) || (state_q == S_REQ_HI);
    assign misaligned = (ENABLE_C == 0) && PC_i[1];
    assign buf_hit    = (BUF_EN != 0) && buf_valid_q && !buf_inv_i
                        && (buf_tag_q == PC_i[31:2]);
    assign cache_ok   = (BUF_EN != 0) && !nocache_q && !buf_inv_i;

    // Low word comes from the buffer on a hit, otherwise from memory.
    assign lo_word  = in_idle ? buf_data_q : mem_rdata_i;
    assign lo_pc1   = in_idle ? PC_i[1]    : pc_q[1];
    assign lo_idx   = in_idle ? PC_i[31:2] : pc_q[31:2];
    assign lo_avail = (in_idle && PC_read_i && !misaligned && buf_hit)
                      || ((state_q == S_REQ_LO) && mem_valid_i);

    mystic_fetch_align u_align (
        .word_i    (lo_word),
        .pc1_i     (lo_pc1),
        .half_o    (al_half),
        .is_c_o    (al_is_c),
        .need_hi_o (al_need_hi)
    );

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        addr_d       = addr_q;
        half_d       = half_q;
        pend_instr_d = pend_instr_q;
        pend_c_d     = pend_c_q;
        pend_err_d   = pend_err_q;
        instr_d      = instr_q;
        is_c_d       = is_c_q;
        err_d        = err_q;
        ready_d      = 1'b0;
        buf_valid_d  = buf_valid_q;
        buf_tag_d    = buf_tag_q;
        buf_data_d   = buf_data_q;
        nocache_d    = nocache_q;

        if (buf_inv_i && in_req) begin
            nocache_d = 1'b1;
        end

        case (state_q)
            S_IDLE: begin
                if (PC_read_i) begin
                    pc_d = PC_i[31:1];
                    if (misaligned) begin
                        pend_instr_d = RST_WORD;
                        pend_c_d     = 1'b0;
                        pend_err_d   = 1'b1;
                        state_d      = S_RESP;
                    end else if (!buf_hit) begin
                        addr_d    = {PC_i[31:2], 2'b00};
                        nocache_d = 1'b0;
                        state_d   = S_REQ_LO;
                    end
                end
            end
            S_REQ_LO: begin
                if (mem_valid_i && cache_ok) begin
                    buf_valid_d = 1'b1;
                    buf_tag_d   = pc_q[31:2];
                    buf_data_d  = mem_rdata_i;
                end
            end
            S_REQ_HI: begin
                if (mem_valid_i) begin
                    if (cache_ok) begin
                        buf_valid_d = 1'b1;
                        buf_tag_d   = addr_q[31:2];
                        buf_data_d  = mem_rdata_i;
                    end
                    pend_instr_d = {mem_rdata_i[15:0], half_q};
                    pend_c_d     = 1'b0;
                    pend_err_d   = 1'b0;
                    state_d      = S_RESP;
                end
            end
            S_RESP: begin
                // Publish the whole response together with the strobe.
                instr_d = pend_instr_q;
                is_c_d  = pend_c_q;
                err_d   = pend_err_q;
                ready_d = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        // Shared handling once the low word is known (hit or memory).
        if (lo_avail) begin
            if (al_need_hi) begin
                half_d    = al_half;
                addr_d    = next_word_addr(lo_idx);
                nocache_d = 1'b0;
                state_d   = S_REQ_HI;
            end else begin
                pend_instr_d = al_is_c ? {16'h0000, al_half} : lo_word;
                pend_c_d     = al_is_c;
                pend_err_d   = 1'b0;
                state_d      = S_RESP;
            end
        end

        if (buf_inv_i) begin
            buf_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q      <= S_IDLE;
            pc_q         <= 31'h0;
            addr_q       <= RST_WORD;
            half_q       <= RST_HALF;
            pend_instr_q <= RST_WORD;
            pend_c_q     <= 1'b0;
            pend_err_q   <= 1'b0;
            instr_q      <= RST_WORD;
            is_c_q       <= 1'b0;
            err_q        <= 1'b0;
            ready_q      <= 1'b0;
            buf_valid_q  <= 1'b0;
            buf_tag_q    <= RST_TAG;
            buf_data_q   <= RST_WORD;
            nocache_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            addr_q       <= addr_d;
            half_q       <= half_d;
            pend_instr_q <= pend_instr_d;
            pend_c_q     <= pend_c_d;
            pend_err_q   <= pend_err_d;
            instr_q      <= instr_d;
            is_c_q       <= is_c_d;
            err_q        <= err_d;
            ready_q      <= ready_d;
            buf_valid_q  <= buf_valid_d;
            buf_tag_q    <= buf_tag_d;
            buf_data_q   <= buf_data_d;
            nocache_q    <= nocache_d;
        end
    end

    // Request follows the state directly so reset drops it immediately.
    assign mem_req_o       = in_req;
    assign mem_addr_o      = addr_q;
    assign instr_o         = instr_q;
    assign is_compressed_o = is_c_q;
    assign instr_err_o     = err_q;
    assign instr_ready_o   = ready_q;

endmodule
